// File: rtl/quad_xor_scheduler.sv
// Two-requester round-robin scheduler for one shared external quad XOR.
// Ports: CLK, RST (sync high); REQ/WIDE/A0/B0/A1/B1 requests and operands;
// GNT/DONE one-hot per requester; XA/XB/XY nibble link to the quad XOR;
// Y result word; BUSY while not IDLE. Option macro
// QUAD_XOR_SCHEDULER_PARITY_EN adds output PAR (parity of the final Y).
module quad_xor_scheduler #(
  parameter int PRIO_INIT = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [0:1]  REQ,
  input  logic [0:1]  WIDE,
  input  logic [0:15] A0,
  input  logic [0:15] B0,
  input  logic [0:15] A1,
  input  logic [0:15] B1,
  output logic [0:1]  GNT,
  output logic [0:3]  XA,
  output logic [0:3]  XB,
  input  logic [0:3]  XY,
  output logic [0:15] Y,
  output logic [0:1]  DONE,
  output logic        BUSY
`ifdef QUAD_XOR_SCHEDULER_PARITY_EN
  ,
  output logic        PAR
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [0:1]  gnt_q, gnt_d;
  logic        wide_q, wide_d;
  logic        ptr_q, ptr_d;
  logic [0:15] a_q, a_d;
  logic [0:15] b_q, b_d;
  logic [0:15] y_q, y_d;
  logic        win;
  logic [3:0]  base;

  // Both requesting: pointer decides; otherwise the lone requester wins.
  always_comb begin
    win = 1'b0;
    if (REQ[0] && REQ[1]) begin
      win = ptr_q;
    end else if (REQ[1]) begin
      win = 1'b1;
    end
  end

  // Nibble k occupies bits [4k:4k+3] (bit 0 is the leftmost bit).
  assign base = {k_q, 2'b00};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gnt_d   = gnt_q;
    wide_d  = wide_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    XA      = '0;
    XB      = '0;
    DONE    = '0;
    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d    = RUN;
          k_d        = '0;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          wide_d     = WIDE[win];
          a_d        = win ? A1 : A0;
          b_d        = win ? B1 : B0;
        end
      end
      RUN: begin
        XA = a_q[base +: 4];
        XB = b_q[base +: 4];
        if (k_q == 2'd0) begin
          y_d = '0;
        end
        y_d[base +: 4] = XY;
        if (!wide_q || k_q == 2'd3) begin
          state_d = FIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      FIN: begin
        DONE    = gnt_q;
        gnt_d   = '0;
        ptr_d   = ~gnt_q[1];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      gnt_q   <= '0;
      wide_q  <= 1'b0;
      ptr_q   <= 1'(PRIO_INIT);
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gnt_q   <= gnt_d;
      wide_q  <= wide_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  assign GNT  = gnt_q;
  assign Y    = y_q;
  assign BUSY = (state_q != IDLE);

`ifdef QUAD_XOR_SCHEDULER_PARITY_EN
  logic par_q, par_d;

  // Y is final during FIN, so its parity is taken on the FIN edge.
  always_comb begin
    par_d = par_q;
    if (state_q == FIN) begin
      par_d = ^y_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign PAR = par_q;
`endif

endmodule

// File: tb/tb_quad_xor_scheduler.sv
// Directed testbench for quad_xor_scheduler.
// Models the external quad XOR and checks each scenario against hand values.
module tb_quad_xor_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [0:1]  REQ = '0;
  logic [0:1]  WIDE = '0;
  logic [0:15] A0 = '0;
  logic [0:15] B0 = '0;
  logic [0:15] A1 = '0;
  logic [0:15] B1 = '0;
  logic [0:1]  GNT;
  logic [0:3]  XA;
  logic [0:3]  XB;
  logic [0:3]  XY;
  logic [0:15] Y;
  logic [0:1]  DONE;
  logic        BUSY;
`ifdef QUAD_XOR_SCHEDULER_PARITY_EN
  logic        PAR;
`endif

  int checks = 0;
  int errors = 0;

  quad_xor_scheduler #(.PRIO_INIT(0)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WIDE(WIDE),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .GNT(GNT), .XA(XA), .XB(XB), .XY(XY),
    .Y(Y), .DONE(DONE), .BUSY(BUSY)
`ifdef QUAD_XOR_SCHEDULER_PARITY_EN
    , .PAR(PAR)
`endif
  );

  // External 74x86-style quad XOR.
  assign XY = XA ^ XB;

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ = 2'b11;
    tick();
    tick();
    RST = 1'b0;
    REQ = 2'b00;
    checks++;
    if (GNT !== 2'b00 || DONE !== 2'b00) begin
      errors++;
      $display("FAIL reset_gnt_done: gnt=%b done=%b want 00 00", GNT, DONE);
    end
    checks++;
    if (XA !== 4'h0 || XB !== 4'h0 || Y !== 16'h0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: xa=%h xb=%h y=%h busy=%b want 0", XA, XB, Y, BUSY);
    end
`ifdef QUAD_XOR_SCHEDULER_PARITY_EN
    checks++;
    if (PAR !== 1'b0) begin
      errors++;
      $display("FAIL reset_par: par=%b want 0", PAR);
    end
`endif
  endtask

  task automatic test_narrow();
    REQ = 2'b10;
    WIDE = 2'b00;
    A0 = 16'hF000;
    B0 = 16'hA000;
    tick();
    REQ = 2'b00;
    checks++;
    if (GNT !== 2'b10 || DONE !== 2'b00 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL narrow_run: gnt=%b done=%b busy=%b want 10 00 1", GNT, DONE, BUSY);
    end
    checks++;
    if (XA !== 4'hF || XB !== 4'hA) begin
      errors++;
      $display("FAIL narrow_nib: xa=%h xb=%h want f a", XA, XB);
    end
    tick();
    checks++;
    if (DONE !== 2'b10 || GNT !== 2'b10 || Y !== 16'h5000) begin
      errors++;
      $display("FAIL narrow_fin: done=%b gnt=%b y=%h want 10 10 5000", DONE, GNT, Y);
    end
    checks++;
    if (XA !== 4'h0 || XB !== 4'h0) begin
      errors++;
      $display("FAIL narrow_fin_x: xa=%h xb=%h want 0 0", XA, XB);
    end
    tick();
    checks++;
    if (GNT !== 2'b00 || DONE !== 2'b00 || BUSY !== 1'b0 || Y !== 16'h5000) begin
      errors++;
      $display("FAIL narrow_idle: gnt=%b done=%b busy=%b y=%h want 00 00 0 5000",
               GNT, DONE, BUSY, Y);
    end
  endtask

  task automatic test_wide();
    logic [3:0] exp_a [4];
    exp_a = '{4'h1, 4'h2, 4'h3, 4'h4};
    REQ = 2'b01;
    WIDE = 2'b01;
    A1 = 16'h1234;
    B1 = 16'hFFFF;
    tick();
    REQ = 2'b00;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (XA !== exp_a[k] || XB !== 4'hF || GNT !== 2'b01 || DONE !== 2'b00) begin
        errors++;
        $display("FAIL wide_pass%0d: xa=%h xb=%h gnt=%b done=%b want %h f 01 00",
                 k, XA, XB, GNT, DONE, exp_a[k]);
      end
      tick();
    end
    checks++;
    if (DONE !== 2'b01 || Y !== 16'hEDCB) begin
      errors++;
      $display("FAIL wide_fin: done=%b y=%h want 01 edcb", DONE, Y);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || Y !== 16'hEDCB || DONE !== 2'b00) begin
      errors++;
      $display("FAIL wide_hold: busy=%b y=%h done=%b want 0 edcb 00", BUSY, Y, DONE);
    end
`ifdef QUAD_XOR_SCHEDULER_PARITY_EN
    checks++;
    if (PAR !== 1'b1) begin
      errors++;
      $display("FAIL wide_par: par=%b want 1", PAR);
    end
`endif
  endtask

  task automatic test_contention();
    logic [0:1]  exp_g [3];
    logic [0:15] exp_y [3];
    exp_g = '{2'b10, 2'b01, 2'b10};
    exp_y = '{16'h3000, 16'hC000, 16'h3000};
    RST = 1'b1;
    tick();
    RST = 1'b0;
    WIDE = 2'b00;
    A0 = 16'h1000;
    B0 = 16'h2000;
    A1 = 16'h4000;
    B1 = 16'h8000;
    REQ = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (GNT !== exp_g[t]) begin
        errors++;
        $display("FAIL cont_gnt%0d: gnt=%b want %b", t, GNT, exp_g[t]);
      end
      tick();
      checks++;
      if (DONE !== exp_g[t] || Y !== exp_y[t]) begin
        errors++;
        $display("FAIL cont_done%0d: done=%b y=%h want %b %h",
                 t, DONE, Y, exp_g[t], exp_y[t]);
      end
      tick();
      checks++;
      if (BUSY !== 1'b0 || GNT !== 2'b00) begin
        errors++;
        $display("FAIL cont_idle%0d: busy=%b gnt=%b want 0 00", t, BUSY, GNT);
      end
    end
    REQ = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    REQ = 2'b10;
    WIDE = 2'b10;
    A0 = 16'h1234;
    B0 = 16'hFFFF;
    tick();
    REQ = 2'b00;
    tick();
    checks++;
    if (XA !== 4'h2 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: xa=%h busy=%b want 2 1", XA, BUSY);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (GNT !== 2'b00 || DONE !== 2'b00 || XA !== 4'h0 || XB !== 4'h0 ||
        Y !== 16'h0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: gnt=%b done=%b xa=%h xb=%h y=%h busy=%b want all 0",
               GNT, DONE, XA, XB, Y, BUSY);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DONE !== 2'b00 || BUSY !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_quiet: activity seen=%b want 0", seen);
    end
  endtask

  task automatic test_operand_change();
    REQ = 2'b10;
    WIDE = 2'b00;
    A0 = 16'hFFFF;
    B0 = 16'h0000;
    tick();
    A0 = 16'h0000;
    B0 = 16'h5555;
    WIDE = 2'b11;
    REQ = 2'b01;
    checks++;
    if (XA !== 4'hF || XB !== 4'h0 || GNT !== 2'b10) begin
      errors++;
      $display("FAIL opchg_run: xa=%h xb=%h gnt=%b want f 0 10", XA, XB, GNT);
    end
    tick();
    checks++;
    if (DONE !== 2'b10 || Y !== 16'hF000) begin
      errors++;
      $display("FAIL opchg_fin: done=%b y=%h want 10 f000", DONE, Y);
    end
    REQ = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_wide();
    test_contention();
    test_reset_mid_run();
    test_operand_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
